// File: rtl/ram_bank_clr.sv
// Word-addressed register bank with a one-word-per-cycle bulk-clear sweep,
// a busy flag for the sweep and a sticky flag for loads that were discarded.
module ram_bank_clr #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              drop_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;

  // A clear request always beats a same-cycle load; the load is reported as dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wrEn    = 1'b0;
    wrAddr  = address;
    wrData  = in;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
          if (load) err_d = 1'b1;
        end else if (load) begin
          wrEn = 1'b1;
        end
      end
      default: begin
        wrEn   = 1'b1;
        wrAddr = idx_q;
        wrData = '0;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
        if (load) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset of its own; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (!reset && wrEn) mem_q[wrAddr] <= wrData;
  end

  assign out      = mem_q[address];
  assign busy     = (state_q == CLEAR);
  assign drop_err = err_q;

endmodule

// File: tb/tb_ram_bank_clr.sv
// Directed self-checking bench for ram_bank_clr (WIDTH=16, ADDR_W=3).
module tb_ram_bank_clr;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  ram_bank_clr #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
    .clear(clear), .out(out), .busy(busy), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic readAt(input string tag, input logic [2:0] a, input logic [15:0] expected);
    address = a;
    #1;
    checkOutput(tag, {16'h0, out}, {16'h0, expected});
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic runSweep(input string tag);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput(tag, {31'h0, busy}, (k < 8) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; in = '0; load = 1'b0; address = '0; clear = 1'b0;
    #2;

    // Test 1: reset then the power-on sweep
    step();
    reset = 1'b0;
    checkOutput("rst_busy", {31'h0, busy}, 32'd1);
    checkOutput("rst_err", {31'h0, drop_err}, 32'd0);
    runSweep("t1_busy");
    for (int i = 0; i < 8; i++) readAt("t1_zero", 3'(i), 16'h0000);
    checkOutput("t1_err", {31'h0, drop_err}, 32'd0);

    // Test 2: single writes are visible immediately and independent
    applyStimulus(3'd5, 16'hBEEF);
    readAt("t2_a5", 3'd5, 16'hBEEF);
    readAt("t2_a4", 3'd4, 16'h0000);
    applyStimulus(3'd0, 16'h1234);
    readAt("t2_a5b", 3'd5, 16'hBEEF);
    readAt("t2_a0", 3'd0, 16'h1234);

    // Test 3: fill, clear, watch word 3 fall at the 4th sweep edge
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 16'h00A0 + 16'(i));
    readAt("t3_fill7", 3'd7, 16'h00A7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checkOutput("t3_entry", {31'h0, busy}, 32'd1);
    readAt("t3_a3pre", 3'd3, 16'h00A3);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("t3_a3", {16'h0, out}, (k < 4) ? 32'h00A3 : 32'h0);
      checkOutput("t3_busy", {31'h0, busy}, (k < 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) readAt("t3_zero", 3'(i), 16'h0000);

    // Test 4: load during a sweep is dropped and the flag is sticky
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    applyStimulus(3'd7, 16'hFFFF);
    checkOutput("t4_err", {31'h0, drop_err}, 32'd1);
    for (int k = 3; k <= 8; k++) step();
    checkOutput("t4_done", {31'h0, busy}, 32'd0);
    readAt("t4_a7", 3'd7, 16'h0000);
    applyStimulus(3'd1, 16'h0042);
    readAt("t4_a1", 3'd1, 16'h0042);
    checkOutput("t4_errw", {31'h0, drop_err}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    runSweep("t4_busy2");
    checkOutput("t4_errc", {31'h0, drop_err}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("t4_errr", {31'h0, drop_err}, 32'd0);
    checkOutput("t4_busyr", {31'h0, busy}, 32'd1);
    runSweep("t4_busy3");

    // Test 5: clear and load on the same idle edge
    applyStimulus(3'd2, 16'h7777);
    readAt("t5_pre", 3'd2, 16'h7777);
    address = 3'd2; in = 16'h5555; load = 1'b1; clear = 1'b1;
    step();
    load = 1'b0; clear = 1'b0;
    checkOutput("t5_busy", {31'h0, busy}, 32'd1);
    checkOutput("t5_err", {31'h0, drop_err}, 32'd1);
    runSweep("t5_sweep");
    readAt("t5_a2", 3'd2, 16'h0000);

    // Test 6: reset at the 3rd sweep edge restarts the sweep; clear mid-sweep is ignored
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 16'h0C00 + 16'(i));
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("t6_busy", {31'h0, busy}, 32'd1);
    checkOutput("t6_err", {31'h0, drop_err}, 32'd0);
    readAt("t6_a1", 3'd1, 16'h0000);
    readAt("t6_a2", 3'd2, 16'h0C02);
    for (int k = 1; k <= 8; k++) begin
      clear = (k == 3);
      step();
      checkOutput("t6_sweep", {31'h0, busy}, (k < 8) ? 32'd1 : 32'd0);
    end
    clear = 1'b0;
    step();
    checkOutput("t6_idle", {31'h0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) readAt("t6_zero", 3'(i), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank_clr.md
Name: ram_bank_clr

Overview:
- Parametrised successor to the single-bit load register: a bank of 2^ADDR_W registers, each WIDTH bits wide, with a shared data input, an address and a load strobe.
- Adds a sequential bulk-clear engine that zeroes one word per cycle, with a busy flag and a sticky error flag for dropped writes.
- Sits in the memory layer of the CPU datapath, alongside the RAM8/RAM64-class blocks, and replaces fixed-size RAM chips where clear-on-reset is needed.

Parameters:
- WIDTH, 16, data bits per word (>=1).
- ADDR_W, 3, address bits; DEPTH = 2^ADDR_W words (ADDR_W >= 1).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- load  input  1  write strobe for mem[address].
- address  input  ADDR_W  read/write word select.
- clear  input  1  bulk-clear request, sampled on the rising edge.
- out  output  WIDTH  mem[address], combinational read.
- busy  output  1  high while the clear sweep runs.
- drop_err  output  1  sticky flag: a load was discarded.

Behaviour:
- Storage: DEPTH x WIDTH registers. out = mem[address] combinationally at all times, including during a sweep. A write is visible on out right after the writing edge, with no extra cycle of latency.
- FSM states:
  - IDLE: busy=0.
  - CLEAR: busy=1. Internal sweep counter idx is ADDR_W bits wide.
- Reset (synchronous, highest priority): at the edge where reset=1, the FSM goes to CLEAR, idx=0 and drop_err=0. No memory word is written on that edge. After that edge busy=1.
- Reset held high for several cycles: the FSM stays in CLEAR with idx held at 0; nothing is written. The sweep starts on the first edge with reset=0.
- Reset mid-sweep: the sweep restarts from idx 0. Words already zeroed stay zero.
- IDLE transitions:
  - clear=1 -> CLEAR, idx=0. No write on that edge. If load=1 on the same edge, the load is dropped and drop_err is set to 1 (clear wins).
  - clear=0, load=1 -> mem[address] <= in.
  - Otherwise -> hold.
- CLEAR, on each edge with reset=0:
  - mem[idx] <= 0 and idx <= idx+1.
  - If idx == DEPTH-1: go to IDLE, busy=0 after that edge, idx wraps to 0.
  - busy is therefore high for exactly DEPTH cycles after the entry edge.
- CLEAR with load=1: the write is discarded and drop_err <= 1.
- CLEAR with clear=1: ignored. The sweep neither restarts nor extends.
- drop_err: only reset clears it. It stays 1 through later sweeps and normal writes.
- Reset values: busy=1 (sweep pending) and drop_err=0. out follows memory, so it is undefined until the first sweep completes and all-zero after busy falls.
- Word index: address and idx index words directly; no out-of-range values are possible since DEPTH = 2^ADDR_W.

Test Plan (WIDTH=16, ADDR_W=3):
1. Reset for 1 cycle, then idle -> busy=1 for exactly 8 edges then 0; out=0x0000 for address 0..7; drop_err=0.
2. After the sweep: load=1, address=5, in=0xBEEF for one edge, then load=0 -> out=0xBEEF at address 5; address 4 still reads 0x0000. Write 0x1234 to address 0 -> address 5 still reads 0xBEEF.
3. Fill all 8 words with 0x00A0+i, then pulse clear -> busy high 8 cycles. Sample address 3: it reads 0x00A3 until the 4th sweep edge and 0x0000 after. All words 0 once busy falls.
4. During a sweep: load=1, address=7, in=0xFFFF -> the write is lost (address 7 reads 0), drop_err=1. drop_err stays 1 through a normal write and a further clear; only reset returns it to 0.
5. In IDLE: clear=1 and load=1 on the same edge (address=2, in=0x5555) -> sweep starts, address 2 reads 0 afterwards, drop_err=1.
6. Reset asserted at the 3rd sweep edge -> idx restarts at 0; busy stays high for 8 more edges after reset is released. A clear pulse during the sweep does not lengthen busy.
